// File: rtl/dcache_backing_mem.sv
`timescale 1ns / 1ps
// dcache_backing_mem
//   Line-granular backing memory that sits below the data cache. It answers
//   line fills (reads) and write-backs (writes) after a programmable latency.
//   Bursts move one beat per cycle.
//
//   Configuration macro: BACKING_MEM_CRITICAL_WORD_FIRST_EN
//     defined   : a fill burst starts at the requested word and wraps
//                 within the line.
//     undefined : a fill burst always starts at the line base.
//   Write-back bursts always start at the line base.
//
// Ports
//   clock, reset_n          rising-edge clock, async active-low reset
//   req_valid/req_ready     request handshake (req_ready high only in IDLE)
//   req_write               1 = write-back, 0 = line fill
//   req_addr                byte address; bits [2:0] are ignored
//   wdata/wdata_valid       write-back beats
//   wdata_ready             high only while write beats are being consumed
//   rdata/rdata_valid       fill beats, no backpressure
//   rdata_last              marks the final fill beat
//   wr_done                 one-cycle pulse once a write-back is committed
module dcache_backing_mem #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 256,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              rdata_last,
  output logic              wr_done
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = IDX_W - OFF_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_WAIT
  } state_e;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Power-up contents: word i holds its own index.
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  // NOTE: the array has no reset. Clearing it would need one write per word,
  // and the contents must survive a reset anyway.
  mem_t mem = mem_init();

  state_e              state_q;
  logic [LINE_W-1:0]   line_q;      // line number of the active request
  logic [OFF_W-1:0]    beat_q;      // beat being shown (read) / expected (write)
  logic [LAT_W-1:0]    cnt_q;       // latency down-counter
  logic [DATA_W-1:0]   rdata_q;
  logic                rdata_valid_q;
  logic                rdata_last_q;
  logic                wr_done_q;
  logic [OFF_W-1:0]    start_w;     // first word offset of a fill burst

`ifdef BACKING_MEM_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]    start_q;
  assign start_w = start_q;
`else
  assign start_w = '0;
`endif

  // Bits of the byte address that select nothing.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:3+IDX_W], req_addr[2:0]};

  // The fill word loaded at this edge: beat 0 when leaving RD_WAIT, otherwise
  // the beat after the one on rdata. The offset sum stays OFF_W bits wide, so
  // it wraps inside the line.
  logic [OFF_W-1:0] rd_beat_next;
  logic [IDX_W-1:0] rd_idx;

  // NOTE: every always_comb output gets a value on every path. This avoids
  // inferred latches.
  always_comb begin
    rd_beat_next = '0;
    if (state_q == RD_BURST) rd_beat_next = beat_q + 1'b1;
    rd_idx = {line_q, start_w + rd_beat_next};
  end

  // Write port. A reset forces state_q to IDLE, so an aborted burst keeps
  // only the beats it had already consumed.
  always_ff @(posedge clock) begin
    if (state_q == WR_BURST && wdata_valid) mem[{line_q, beat_q}] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      line_q        <= '0;
      beat_q        <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      wr_done_q     <= 1'b0;
`ifdef BACKING_MEM_CRITICAL_WORD_FIRST_EN
      start_q       <= '0;
`endif
    end else begin
      wr_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            line_q  <= req_addr[3+OFF_W +: LINE_W];
`ifdef BACKING_MEM_CRITICAL_WORD_FIRST_EN
            start_q <= req_addr[3 +: OFF_W];
`endif
            beat_q  <= '0;
            cnt_q   <= LAT_W'(LATENCY - 1);
            state_q <= req_write ? WR_BURST : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            rdata_q       <= mem[rd_idx];
            rdata_valid_q <= 1'b1;
            rdata_last_q  <= 1'b0;
            beat_q        <= '0;
            state_q       <= RD_BURST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RD_BURST: begin
          // beat_q is the beat currently shown. The last beat stays valid for
          // its own cycle and the FSM returns to IDLE after it.
          if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            state_q       <= IDLE;
          end else begin
            beat_q       <= rd_beat_next;
            rdata_q      <= mem[rd_idx];
            rdata_last_q <= (beat_q == OFF_W'(LINE_WORDS - 2));
          end
        end
        WR_BURST: begin
          if (wdata_valid) begin
            if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
              cnt_q   <= LAT_W'(LATENCY - 1);
              state_q <= WR_WAIT;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        WR_WAIT: begin
          if (cnt_q == '0) begin
            wr_done_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WR_BURST);
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata_last  = rdata_last_q;
  assign wr_done     = wr_done_q;

endmodule
